mxv_vxv_sequencer: RTL

MXV_VXV_SEQUENCER -- requirements
Module: mxv_vxv_sequencer

---
 rtl/seq_pkg.sv | 50 +++++
 rtl/phase_timer.sv | 23 ++
 rtl/mxv_vxv_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the mXv/vXv phase sequencer: state encoding,
// default timing constants and the per-state phase output decode.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } seq_state_e;

  localparam int DEF_GAP_CYCLES    = 5;
  localparam int DEF_WARMUP_CYCLES = 2;

  typedef struct packed {
    logic dp_reset;
    logic mxv;
    logic vxv;
    logic busy;
    logic done;
    logic wdog_err;
  } phase_out_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Exactly one of mxv/vxv is high in every state; only RUN runs mXv.
  function automatic phase_out_t decode_phase(input seq_state_e s);
    phase_out_t o;
    o = '{dp_reset: 1'b0, mxv: 1'b0, vxv: 1'b1, busy: 1'b0, done: 1'b0, wdog_err: 1'b0};
    case (s)
      S_IDLE:   o.dp_reset = 1'b1;
      S_WARMUP: begin o.dp_reset = 1'b1; o.busy = 1'b1; end
      S_ARM:    o.busy = 1'b1;
      S_RUN:    begin o.mxv = 1'b1; o.vxv = 1'b0; o.busy = 1'b1; end
      S_GAP:    o.busy = 1'b1;
      S_DONE:   o.done = 1'b1;
      S_ERROR:  begin o.dp_reset = 1'b1; o.wdog_err = 1'b1; end
      default:  o.dp_reset = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; one instance times WARMUP,
// GAP and the RUN watchdog since those phases never overlap.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= load_value;
    else if (count != '0)    count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mxv_vxv_sequencer.sv
// Sequences a solver datapath through warmup, alternating mXv/vXv phases,
// and termination on halt, iteration limit or watchdog timeout.
module mxv_vxv_sequencer
  import seq_pkg::*;
#(
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int ITER_W        = 16,
  parameter int MAX_ITER      = 256,
  parameter int WDOG_CYCLES   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              finish,
  input  logic              halt,
  output logic              dp_reset,
  output logic              reset_mXv1,
  output logic              reset_vXv1,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              max_hit,
  output logic              wdog_err,
  output logic [2:0]        state_dbg
);

  localparam int TW = $clog2(max3(WDOG_CYCLES, GAP_CYCLES, WARMUP_CYCLES) + 1);
  // Timer is loaded with N-1 so a phase lasts exactly N cycles.
  localparam logic [TW-1:0]     WARMUP_LOAD = TW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]     WDOG_LOAD   = TW'(WDOG_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(MAX_ITER);

  seq_state_e        state, state_next;
  phase_out_t        out_next;
  logic              t_load, t_zero;
  logic [TW-1:0]     t_load_value;
  logic              fin_armed, fin_qual, gap_exit, at_limit;
  logic [ITER_W-1:0] iter_inc;

  phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_load_value),
    .zero       (t_zero)
  );

  assign iter_inc  = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);
  assign at_limit  = (iter_inc == ITER_LIMIT);
  assign fin_qual  = (state == S_RUN) && fin_armed && finish;
  assign gap_exit  = (state == S_GAP) && t_zero && !halt;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = S_WARMUP;
        S_WARMUP: if (t_zero) state_next = S_ARM;
        S_ARM:    state_next = halt ? S_DONE : S_RUN;
        S_RUN: begin
          if (halt)          state_next = S_DONE;
          else if (fin_qual) state_next = S_GAP;
          else if (t_zero)   state_next = S_ERROR;
        end
        S_GAP: begin
          if (halt)        state_next = S_DONE;
          else if (t_zero) state_next = at_limit ? S_DONE : S_RUN;
        end
        S_DONE:   if (start) state_next = S_WARMUP;
        S_ERROR:  state_next = S_ERROR;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_next     = decode_phase(state_next);
    t_load       = 1'b0;
    t_load_value = '0;
    if (state_next != state) begin
      case (state_next)
        S_WARMUP: begin t_load = 1'b1; t_load_value = WARMUP_LOAD; end
        S_RUN:    begin t_load = 1'b1; t_load_value = WDOG_LOAD;   end
        S_GAP:    begin t_load = 1'b1; t_load_value = GAP_LOAD;    end
        default:  ;
      endcase
    end
  end

  // Outputs are registered from the next state so they flip with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_reset   <= 1'b1;
      reset_mXv1 <= 1'b0;
      reset_vXv1 <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      wdog_err   <= 1'b0;
    end else begin
      dp_reset   <= out_next.dp_reset;
      reset_mXv1 <= out_next.mxv;
      reset_vXv1 <= out_next.vxv;
      busy       <= out_next.busy;
      done       <= out_next.done;
      wdog_err   <= out_next.wdog_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_count <= '0;
      max_hit    <= 1'b0;
    end else if (abort || (start && (state == S_IDLE || state == S_DONE))) begin
      iter_count <= '0;
      max_hit    <= 1'b0;
    end else if (gap_exit) begin
      iter_count <= iter_inc;
      if (at_limit) max_hit <= 1'b1;
    end
  end

  // A finish level left over from the previous phase must drop before it counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fin_armed <= 1'b0;
    else if (state != S_RUN) fin_armed <= 1'b0;
    else if (!finish)        fin_armed <= 1'b1;
  end

endmodule
